md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multi-cycle RV32M multiply/divide execution unit, beside the ALU in the execute stage.
- Consumes the operands and md_funct3_e code from decode for OPCODE_OP instructions with funct7=0000001.
- Returns the 32-bit result and destination tag to writeback over a valid/ready handshake.
- Multiply is two-cycle; divide/remainder is an iterative radix-2 restoring divider.

Parameters:
XLEN, 32, operand and result width
TAG_W, 5, width of destination register tag carried alongside the op

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid_i  input  1  decode presents an M-extension op
in_ready_o  output  1  unit can accept an op this cycle
funct3_i  input  3  md_funct3_e (MUL..REMU)
op_a_i  input  XLEN  rs1 value (dividend / multiplicand)
op_b_i  input  XLEN  rs2 value (divisor / multiplier)
rd_i  input  TAG_W  destination register index
flush_i  input  1  pipeline flush; abort any in-flight op
out_valid_o  output  1  result valid, held until accepted
out_ready_i  input  1  writeback accepts result
result_o  output  XLEN  final result
rd_o  output  TAG_W  destination tag of result_o

Behaviour:
- Reset (async, rst=1): state IDLE; in_ready_o=1, out_valid_o=0, result_o=0, rd_o=0, iteration counter 0, all operand registers 0.
- States:
  - IDLE: in_ready_o = !flush_i; otherwise 0.
  - MUL, DIV: compute.
  - DONE: out_valid_o=1.
- Accept: in_valid_i && in_ready_o at a rising edge; latch funct3, operands, rd.
- MUL family:
  - IDLE -> MUL. In MUL, form the 64-bit product and register it; -> DONE next edge.
  - out_valid_o rises 2 edges after the accept edge.
  - Operand extension: MUL low 32 bits; MULH signed x signed; MULHSU signed rs1 x unsigned rs2; MULHU unsigned x unsigned.
  - High variants return bits [63:32].
- DIV family:
  - Signed ops (DIV/REM): take absolute values and record quotient sign (a_sign^b_sign) and remainder sign (a_sign).
  - Counter loads XLEN-1. One quotient bit per cycle in DIV, MSB first. Counter decrements; at 0, apply sign correction and -> DONE.
  - out_valid_o rises XLEN+1 (33) edges after the accept edge.
- Special cases: decided at accept, IDLE -> DONE directly, out_valid_o 1 edge after accept.
  - Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> op_a.
  - Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- DONE:
  - result_o/rd_o stable while out_valid_o=1 && out_ready_i=0.
  - On out_valid_o && out_ready_i -> IDLE and out_valid_o=0 next cycle. No back-to-back accept in the same cycle; in_ready_o=0 in DONE.
- flush_i (synchronous, any state): next edge -> IDLE, out_valid_o=0, counter cleared, no result emitted.
  - Flush wins over a simultaneous accept or output handshake.
- Reset mid-operation: immediate return to reset values; no partial result is ever presented.
- Unused funct3 values are impossible (all 8 are defined); no error output.

Test Plan:
- Reset then idle: rst pulse mid-DIV (counter ~15) -> out_valid_o=0, in_ready_o=1 immediately; no stale result afterwards.
- Multiplies: MUL 0x7FFFFFFF*2 -> 0xFFFFFFFE; MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFE. Each valid exactly 2 edges after accept, rd_o matches.
- Divides: DIV -7/2 -> 0xFFFFFFFD; REM -7%2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2. Each valid 33 edges after accept.
- Corner divides: DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0. Each valid 1 edge after accept.
- Flush: flush_i at iteration 10 of DIV -> IDLE next edge, no out_valid_o.
- Flush in IDLE: flush_i with in_valid_i in IDLE -> op not accepted.
- Backpressure: out_ready_i=0 for 5 cycles in DONE -> result_o/rd_o unchanged, in_ready_o=0; release -> IDLE next edge, a new op is accepted the following cycle.

Source files
------------

// File: rtl/md_unit.sv
// RV32M multiply/divide unit: two-cycle multiply, radix-2 restoring divide,
// single op in flight, result held on a valid/ready handshake until accepted.
module md_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       funct3_i,
  input  logic [XLEN-1:0]  op_a_i,
  input  logic [XLEN-1:0]  op_b_i,
  input  logic [TAG_W-1:0] rd_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] rd_o
);

  localparam int unsigned CntW     = $clog2(XLEN);
  localparam logic [2:0]  F3Mulh   = 3'd1;
  localparam logic [2:0]  F3Mulhsu = 3'd2;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e            state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [XLEN-1:0]   op_a_q, op_a_d;   // multiplicand, or dividend shifting into quotient
  logic [XLEN-1:0]   op_b_q, op_b_d;   // multiplier, or divisor magnitude
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [TAG_W-1:0]  rd_q, rd_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;

  // Accept-time decode of the incoming op
  logic            accept, div_op, div_signed, div_rem, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] abs_a, abs_b;

  assign in_ready_o = (state_q == StIdle) && !flush_i;
  assign accept     = in_valid_i && in_ready_o;
  assign div_op     = funct3_i[2];
  assign div_signed = !funct3_i[0];
  assign div_rem    = funct3_i[1];
  assign a_neg      = div_signed && op_a_i[XLEN-1];
  assign b_neg      = div_signed && op_b_i[XLEN-1];
  assign abs_a      = a_neg ? -op_a_i : op_a_i;
  assign abs_b      = b_neg ? -op_b_i : op_b_i;
  assign div_zero   = (op_b_i == '0);
  assign div_ovf    = div_signed && (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == '1);

  // Multiply: extend both operands to 2*XLEN so one unsigned product covers every variant
  logic                mul_a_sgn, mul_b_sgn;
  logic [2*XLEN-1:0]   mul_a_ext, mul_b_ext, product;

  assign mul_a_sgn = (funct3_q == F3Mulh) || (funct3_q == F3Mulhsu);
  assign mul_b_sgn = (funct3_q == F3Mulh);
  assign mul_a_ext = {{XLEN{mul_a_sgn && op_a_q[XLEN-1]}}, op_a_q};
  assign mul_b_ext = {{XLEN{mul_b_sgn && op_b_q[XLEN-1]}}, op_b_q};
  assign product   = mul_a_ext * mul_b_ext;

  // Divide step: shift next dividend bit into the partial remainder and try a subtract
  logic [XLEN:0]   div_shift, div_diff;
  logic            q_bit;
  logic [XLEN-1:0] rem_step, quo_step, quo_fin, rem_fin;

  assign div_shift = {rem_q, op_a_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, op_b_q};
  assign q_bit     = !div_diff[XLEN];
  assign rem_step  = q_bit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
  assign quo_step  = {op_a_q[XLEN-2:0], q_bit};
  assign quo_fin   = neg_quo_q ? -quo_step : quo_step;
  assign rem_fin   = neg_rem_q ? -rem_step : rem_step;

  // Next-state logic; flush overrides everything else
  always_comb begin
    state_d   = state_q;
    funct3_d  = funct3_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    rem_d     = rem_q;
    result_d  = result_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          funct3_d = funct3_i;
          rd_d     = rd_i;
          if (!div_op) begin
            op_a_d  = op_a_i;
            op_b_d  = op_b_i;
            state_d = StMul;
          end else if (div_zero) begin
            result_d = div_rem ? op_a_i : '1;
            state_d  = StDone;
          end else if (div_ovf) begin
            result_d = div_rem ? '0 : op_a_i;
            state_d  = StDone;
          end else begin
            op_a_d    = abs_a;
            op_b_d    = abs_b;
            rem_d     = '0;
            cnt_d     = CntW'(XLEN - 1);
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            state_d   = StDiv;
          end
        end
      end
      StMul: begin
        result_d = (funct3_q[1:0] == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
        state_d  = StDone;
      end
      StDiv: begin
        rem_d  = rem_step;
        op_a_d = quo_step;
        cnt_d  = cnt_q - CntW'(1);
        if (cnt_q == '0) begin
          result_d = funct3_q[1] ? rem_fin : quo_fin;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (flush_i) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      funct3_q  <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      rem_q     <= '0;
      result_q  <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      funct3_q  <= funct3_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      rem_q     <= rem_d;
      result_q  <= result_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign out_valid_o = (state_q == StDone);
  assign result_o    = result_q;
  assign rd_o        = rd_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: the driver pushes reference results, a monitor
// pops and compares result, tag, latency and hold stability.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i, in_ready_o, flush_i, out_valid_o, out_ready_i;
  logic [2:0]  funct3_i;
  logic [31:0] op_a_i, op_b_i, result_o;
  logic [4:0]  rd_i, rd_o;

  always #5 clk = ~clk;

  md_unit #(.XLEN(32), .TAG_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .funct3_i    (funct3_i),
    .op_a_i      (op_a_i),
    .op_b_i      (op_b_i),
    .rd_i        (rd_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .rd_o        (rd_o)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   edges  = 0;

  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Reference: RV32M semantics via 64-bit integer arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    case (f)
      3'd0: begin p = ua * ub; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      3'd6: r = (b == 0) ? a : 32'(sa % sb);
      default: r = (b == 0) ? a : 32'(ua % ub);
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return 2;
    if (b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: first cycle of each valid result is checked against the queue head
  initial begin : monitor
    exp_t cur;
    bit   active;
    active = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        active = 1'b0;
      end else if (out_valid_o) begin
        if (!active) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_valid", 32'(out_valid_o), 32'd0);
          end else begin
            cur    = sb_q.pop_front();
            active = 1'b1;
            chk("result", result_o, cur.res);
            chk("rd", 32'(rd_o), 32'(cur.rd));
            chk("latency", 32'(edges - cur.acc + 1), 32'(cur.lat));
          end
        end else begin
          chk("hold_result", result_o, cur.res);
          chk("hold_rd", 32'(rd_o), 32'(cur.rd));
        end
        if (out_ready_i) active = 1'b0;
      end
    end
  end

  // Called in the low clock phase; returns in the low phase after the accept edge
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit track, output int waited);
    exp_t e;
    in_valid_i = 1'b1;
    funct3_i   = f;
    op_a_i     = a;
    op_b_i     = b;
    rd_i       = rd;
    waited     = 0;
    while (!in_ready_o && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready_o) begin
      chk("accept_timeout", 32'(in_ready_o), 32'd1);
      in_valid_i = 1'b0;
      return;
    end
    if (track) begin
      e.res = ref_result(f, a, b);
      e.rd  = rd;
      e.acc = edges + 1;
      e.lat = ref_lat(f, a, b);
      sb_q.push_back(e);
    end
    @(negedge clk);
    in_valid_i = 1'b0;
  endtask

  // Wait for the result, hold it off for 'hold' cycles, then accept it
  task automatic finish_op(input int hold);
    int n;
    n = 0;
    out_ready_i = 1'b0;
    while (!out_valid_o && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid_o) begin
      chk("valid_timeout", 32'(out_valid_o), 32'd1);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      chk("bp_in_ready", 32'(in_ready_o), 32'd0);
      @(negedge clk);
    end
    out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
  endtask

  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input int hold);
    int w;
    issue(f, a, b, rd, 1'b1, w);
    finish_op(hold);
  endtask

  initial begin : driver
    int w;
    rst         = 1'b1;
    in_valid_i  = 1'b0;
    flush_i     = 1'b0;
    out_ready_i = 1'b0;
    funct3_i    = 3'd0;
    op_a_i      = 32'd0;
    op_b_i      = 32'd0;
    rd_i        = 5'd0;
    #2;
    chk("rst_in_ready", 32'(in_ready_o), 32'd1);
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_rd", 32'(rd_o), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Multiplies
    run(3'd0, 32'h7FFF_FFFF, 32'h2,         5'd1, 0);
    run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1);
    run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0);
    run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 2);
    // Divides
    run(3'd4, 32'hFFFF_FFF9, 32'd2,   5'd5, 0);
    run(3'd6, 32'hFFFF_FFF9, 32'd2,   5'd6, 0);
    run(3'd5, 32'd100,       32'd7,   5'd7, 1);
    run(3'd7, 32'd100,       32'd7,   5'd8, 0);
    // Corner divides
    run(3'd5, 32'd5,         32'd0,         5'd9,  0);
    run(3'd6, 32'd5,         32'd0,         5'd10, 0);
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0);
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1);

    // Backpressure, then an op accepted on the first idle cycle
    issue(3'd5, 32'd100, 32'd7, 5'd13, 1'b1, w);
    finish_op(5);
    #1;
    chk("bp_release_valid", 32'(out_valid_o), 32'd0);
    chk("bp_release_ready", 32'(in_ready_o), 32'd1);
    issue(3'd0, 32'd3, 32'd5, 5'd14, 1'b1, w);
    chk("bp_next_accept_wait", 32'(w), 32'd0);
    finish_op(0);

    // Flush mid-divide
    issue(3'd4, 32'd1000, 32'd3, 5'd15, 1'b0, w);
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    chk("flush_in_ready", 32'(in_ready_o), 32'd1);
    chk("flush_out_valid", 32'(out_valid_o), 32'd0);
    repeat (40) @(negedge clk);
    chk("flush_no_result", 32'(out_valid_o), 32'd0);

    // Flush in idle blocks acceptance
    in_valid_i = 1'b1;
    funct3_i   = 3'd0;
    op_a_i     = 32'd6;
    op_b_i     = 32'd7;
    rd_i       = 5'd16;
    flush_i    = 1'b1;
    #1;
    chk("idle_flush_ready", 32'(in_ready_o), 32'd0);
    @(negedge clk);
    in_valid_i = 1'b0;
    flush_i    = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_flush_no_valid", 32'(out_valid_o), 32'd0);

    // Reset in the middle of a divide
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd17, 1'b0, w);
    repeat (16) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid_o), 32'd0);
    chk("midrst_in_ready", 32'(in_ready_o), 32'd1);
    chk("midrst_result", result_o, 32'd0);
    chk("midrst_rd", 32'(rd_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_no_result", 32'(out_valid_o), 32'd0);

    // Randomized ops
    for (int i = 0; i < 80; i++) begin
      run(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom_range(0, 31)),
          int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
